pid_pwm_drive: RTL

- Actuator-side end of the PID loop. Accepts the signed controller output through a valid/ready handshake and converts it to sign/magnitude.
- Drives a fixed-period PWM plus a direction line for an H-bridge.
- Generates the one-cycle sample strobe that paces the controller and its sample registers, one strobe per PWM period.
- Duty updates are double-buffered and take effect only at a period boundary, so no runt pulses occur.

---
 rtl/pid_pwm_pkg.sv | 27 ++
 rtl/pid_mag_sat.sv | 36 +++
 rtl/pid_pwm_drive.sv | 109 ++++++++++
 3 files changed

// File: rtl/pid_pwm_pkg.sv
// Shared constants, helper and command record for the PID actuator drive.
//   DefWidth / DefCntWidth / DefShift : default controller word, PWM counter
//                                       and magnitude shift widths.
//   DutyMax()                         : top PWM count for a counter width.
//   pwm_cmd_t                         : {duty, dir, sat}; used for both the
//                                       shadow and the active command.
package pid_pwm_pkg;

  localparam int unsigned DefWidth    = 18;
  localparam int unsigned DefCntWidth = 10;
  localparam int unsigned DefShift    = 7;

  // Duty field is sized for the widest supported counter; narrower
  // counters zero-extend into it.
  localparam int unsigned DutyBits    = 16;

  function automatic int unsigned DutyMax(input int unsigned cnt_width);
    return (32'd1 << cnt_width) - 32'd1;
  endfunction

  typedef struct packed {
    logic [DutyBits-1:0] duty;
    logic                dir;
    logic                sat;
  } pwm_cmd_t;

endpackage

// File: rtl/pid_mag_sat.sv
// Signed controller word -> sign/magnitude duty with saturation.
//   u_in : signed controller output (two's complement), Width bits
//   duty : min(|u_in| >> Shift, DutyMax), CntWidth bits
//   dir  : 1 = negative command
//   sat  : scaled magnitude exceeded DutyMax
// Purely combinational.
module pid_mag_sat
  import pid_pwm_pkg::*;
#(
  parameter int unsigned Width    = DefWidth,
  parameter int unsigned CntWidth = DefCntWidth,
  parameter int unsigned Shift    = DefShift
) (
  input  logic [Width-1:0]    u_in,
  output logic [CntWidth-1:0] duty,
  output logic                dir,
  output logic                sat
);

  localparam logic [Width:0] MaxScaled = (Width+1)'(DutyMax(CntWidth));

  logic [Width:0] w_ext;
  logic [Width:0] w_mag;
  logic [Width:0] w_scaled;

  // One extra bit so the most negative input has a representable magnitude.
  always_comb begin
    w_ext    = {u_in[Width-1], u_in};
    w_mag    = u_in[Width-1] ? ((~w_ext) + {{Width{1'b0}}, 1'b1}) : w_ext;
    w_scaled = w_mag >> Shift;
    sat      = (w_scaled > MaxScaled);
    duty     = sat ? '1 : w_scaled[CntWidth-1:0];
    dir      = u_in[Width-1];
  end

endmodule

// File: rtl/pid_pwm_drive.sv
// Actuator end of the PID loop: handshake-in of the controller word,
// double-buffered duty, fixed-period PWM with direction, per-period strobe.
//   clk, rst      : clock, asynchronous active-low reset
//   enable        : run control; low parks the PWM and clears the active duty
//   u_in/u_valid  : signed controller word and its valid
//   u_ready       : shadow register free
//   pwm_out       : PWM drive (registered)
//   dir_out       : 1 = negative command (registered)
//   sat_flag      : active duty was clipped (registered)
//   sample_tick   : one-cycle strobe per period, cycle after the wrap
module pid_pwm_drive
  import pid_pwm_pkg::*;
#(
  parameter int unsigned Width    = DefWidth,
  parameter int unsigned CntWidth = DefCntWidth,
  parameter int unsigned Shift    = DefShift
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             enable,
  input  logic [Width-1:0] u_in,
  input  logic             u_valid,
  output logic             u_ready,
  output logic             pwm_out,
  output logic             dir_out,
  output logic             sat_flag,
  output logic             sample_tick
);

  localparam logic [CntWidth-1:0] CntMax = CntWidth'(DutyMax(CntWidth));

  logic [CntWidth-1:0] w_duty;
  logic                w_dir;
  logic                w_sat;
  pwm_cmd_t            w_cmd;
  logic                w_wrap;
  logic                w_accept;
  logic                w_apply;

  logic [CntWidth-1:0] r_cnt;
  pwm_cmd_t            r_shadow;
  pwm_cmd_t            r_act;
  logic                r_pending;
  logic                r_ready;

  pid_mag_sat #(
    .Width    (Width),
    .CntWidth (CntWidth),
    .Shift    (Shift)
  ) u_mag_sat (
    .u_in (u_in),
    .duty (w_duty),
    .dir  (w_dir),
    .sat  (w_sat)
  );

  always_comb begin
    w_cmd      = '0;
    w_cmd.duty = DutyBits'(w_duty);
    w_cmd.dir  = w_dir;
    w_cmd.sat  = w_sat;
    w_wrap     = enable && (r_cnt == CntMax);
    w_accept   = u_valid && r_ready;
    // Only a word already pending at the start of the wrap cycle is applied;
    // an accept in that same cycle waits for the following wrap.
    w_apply    = w_wrap && r_pending;
  end

  assign u_ready = r_ready;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_cnt       <= '0;
      r_shadow    <= '0;
      r_act       <= '0;
      r_pending   <= 1'b0;
      r_ready     <= 1'b1;
      pwm_out     <= 1'b0;
      dir_out     <= 1'b0;
      sat_flag    <= 1'b0;
      sample_tick <= 1'b0;
    end else begin
      if (!enable) begin
        r_cnt <= '0;
        r_act <= '0;
      end else begin
        r_cnt <= r_cnt + CntWidth'(1);
        if (w_apply) r_act <= r_shadow;
      end

      if (w_accept) r_shadow <= w_cmd;

      // r_ready mirrors !r_pending so u_ready comes straight from a flop.
      if (w_apply) begin
        r_pending <= 1'b0;
        r_ready   <= 1'b1;
      end else if (w_accept) begin
        r_pending <= 1'b1;
        r_ready   <= 1'b0;
      end

      pwm_out     <= enable && (DutyBits'(r_cnt) < r_act.duty);
      dir_out     <= r_act.dir;
      sat_flag    <= r_act.sat;
      sample_tick <= w_wrap;
    end
  end

endmodule
